// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Issues one load/store per instruction on a request/response data bus,
// formats store strobes/data, and extracts and extends load data.
// Optional build macro MEM_ALIGN_CHECK_EN: adds the ale output and traps
// misaligned half/word accesses without touching the bus.
module mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_result,
  input  logic [31:0] in_rkd_value,
  input  logic [7:0]  in_load_op,
  input  logic        in_res_from_mem,
  input  logic        in_gr_we,
  input  logic        in_mem_we,
  input  logic [4:0]  in_dest,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        ale,
`endif
  output logic [31:0] out_pc,
  output logic [31:0] out_result,
  output logic        out_gr_we,
  output logic [4:0]  out_dest
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] result_reg;
  logic [31:0] rkd_reg;
  logic [7:0]  load_op_reg;
  logic        res_from_mem_reg;
  logic        gr_we_reg;
  logic        mem_we_reg;
  logic [4:0]  dest_reg;
  logic [31:0] load_data_reg;
  logic        data_req_reg;
  logic        out_valid_reg;

  logic        accept;
  logic        in_is_mem;
  logic        misalign;
  logic        go_mem;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;

  // Upstream handshake: free when idle, or when the held result leaves this cycle.
  assign in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign in_is_mem = in_res_from_mem | in_mem_we;

`ifdef MEM_ALIGN_CHECK_EN
  logic in_half;
  logic in_word;
  logic ale_reg;
  assign in_half  = in_load_op[1] | in_load_op[4] | in_load_op[6];
  assign in_word  = in_load_op[2] | in_load_op[7];
  assign misalign = in_is_mem & ((in_half & in_result[0]) |
                                 (in_word & (in_result[1:0] != 2'b00)));
  assign ale      = ale_reg;
`else
  assign misalign = 1'b0;
`endif

  // A misaligned access never reaches the bus.
  assign go_mem = in_is_mem & ~misalign;

  // Main FSM: captures the instruction on accept and tracks the bus beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pc_reg           <= RESET_PC;
      result_reg       <= '0;
      rkd_reg          <= '0;
      load_op_reg      <= '0;
      res_from_mem_reg <= 1'b0;
      gr_we_reg        <= 1'b0;
      mem_we_reg       <= 1'b0;
      dest_reg         <= '0;
      load_data_reg    <= '0;
      data_req_reg     <= 1'b0;
      out_valid_reg    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      ale_reg          <= 1'b0;
`endif
    end else if (accept) begin
      pc_reg           <= in_pc;
      result_reg       <= in_result;
      rkd_reg          <= in_rkd_value;
      load_op_reg      <= in_load_op;
      res_from_mem_reg <= in_res_from_mem;
      gr_we_reg        <= in_gr_we & ~misalign;
      mem_we_reg       <= in_mem_we;
      dest_reg         <= in_dest;
      load_data_reg    <= '0;
      state            <= go_mem ? REQ : DONE;
      data_req_reg     <= go_mem;
      out_valid_reg    <= ~go_mem;
`ifdef MEM_ALIGN_CHECK_EN
      ale_reg          <= misalign;
`endif
    end else begin
      case (state)
        REQ: begin
          // A data_ok in the same cycle belongs to no beat yet; only addr_ok counts.
          if (data_addr_ok) begin
            state        <= WAIT;
            data_req_reg <= 1'b0;
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            state         <= DONE;
            out_valid_reg <= 1'b1;
            if (res_from_mem_reg) load_data_reg <= load_data;
          end
        end
        DONE: begin
          if (out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Load extraction: align the addressed byte/half to bit 0, then extend.
  always_comb begin
    byte_val  = 8'(data_rdata >> {result_reg[1:0], 3'b000});
    half_val  = 16'(data_rdata >> {result_reg[1], 4'b0000});
    load_data = data_rdata;
    if (load_op_reg[0])      load_data = {{24{byte_val[7]}}, byte_val};
    else if (load_op_reg[1]) load_data = {{16{half_val[15]}}, half_val};
    else if (load_op_reg[3]) load_data = {24'h0, byte_val};
    else if (load_op_reg[4]) load_data = {16'h0, half_val};
  end

  // Bus request formatting from the captured access type and address.
  always_comb begin
    data_size  = 2'd2;
    data_wstrb = 4'b0000;
    data_wdata = rkd_reg;
    if (load_op_reg[0] | load_op_reg[3] | load_op_reg[5]) data_size = 2'd0;
    else if (load_op_reg[1] | load_op_reg[4] | load_op_reg[6]) data_size = 2'd1;
    if (load_op_reg[5]) begin
      data_wstrb = 4'b0001 << result_reg[1:0];
      data_wdata = {4{rkd_reg[7:0]}};
    end else if (load_op_reg[6]) begin
      data_wstrb = result_reg[1] ? 4'b1100 : 4'b0011;
      data_wdata = {2{rkd_reg[15:0]}};
    end else if (load_op_reg[7]) begin
      data_wstrb = 4'hF;
    end
  end

  assign data_req   = data_req_reg;
  assign data_wr    = mem_we_reg;
  assign data_addr  = result_reg;
  assign out_valid  = out_valid_reg;
  assign out_pc     = pc_reg;
  assign out_result = res_from_mem_reg ? load_data_reg : result_reg;
  assign out_gr_we  = gr_we_reg;
  assign out_dest   = dest_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with an expected-result queue
// that is drained whenever the stage hands a result to writeback.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_result, in_rkd_value;
  logic [7:0]  in_load_op;
  logic        in_res_from_mem, in_gr_we, in_mem_we;
  logic [4:0]  in_dest;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_result;
  logic        out_gr_we;
  logic [4:0]  out_dest;
`ifdef MEM_ALIGN_CHECK_EN
  logic        ale;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        check_result;
    logic        gr_we;
    logic [4:0]  dest;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   req_cycles = 0;
  int   pushed = 0;
  int   popped = 0;
  int   req_snap;

  always #5 clk = ~clk;

  mem_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_rkd_value(in_rkd_value),
    .in_load_op(in_load_op), .in_res_from_mem(in_res_from_mem),
    .in_gr_we(in_gr_we), .in_mem_we(in_mem_we), .in_dest(in_dest),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef MEM_ALIGN_CHECK_EN
    .ale(ale),
`endif
    .out_pc(out_pc), .out_result(out_result), .out_gr_we(out_gr_we), .out_dest(out_dest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle look at the bus: count requests and drain the scoreboard on a transfer.
  task automatic monitor();
    exp_t e;
    if (data_req === 1'b1) req_cycles++;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", {31'h0, out_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        popped++;
        chk("sb_pc", out_pc, e.pc);
        if (e.check_result) chk("sb_result", out_result, e.result);
        chk("sb_gr_we", {31'h0, out_gr_we}, {31'h0, e.gr_we});
        chk("sb_dest", {27'h0, out_dest}, {27'h0, e.dest});
        $display("xfer pc=%h result=%h gr_we=%0d dest=%0d", out_pc, out_result, out_gr_we, out_dest);
      end
    end
  endtask

  // One clock: monitor at the falling edge, return 1ns after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] res, input logic chk_res,
                          input logic gwe, input logic [4:0] dest);
    exp_t e;
    e.pc = pc; e.result = res; e.check_result = chk_res; e.gr_we = gwe; e.dest = dest;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Present one instruction, confirm it is taken, and record its expected result.
  task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] rkd,
                       input logic [7:0] op, input logic rfm, input logic gwe, input logic mwe,
                       input logic [4:0] dest, input logic [31:0] exp_res, input logic chk_res,
                       input logic exp_gwe);
    in_valid = 1'b1; in_pc = pc; in_result = res; in_rkd_value = rkd; in_load_op = op;
    in_res_from_mem = rfm; in_gr_we = gwe; in_mem_we = mwe; in_dest = dest;
    #1;
    chk("accept_in_ready", {31'h0, in_ready}, 32'h1);
    push_exp(pc, exp_res, chk_res, exp_gwe, dest);
    step();
    in_valid = 1'b0;
  endtask

  // Serve the bus from REQ: optional address/data stalls, then one data beat.
  task automatic mem_beats(input int addr_wait, input int data_wait, input logic [31:0] rdata);
    for (int i = 0; i < addr_wait; i++) begin
      #1 chk("req_held", {31'h0, data_req}, 32'h1);
      step();
    end
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    for (int i = 0; i < data_wait; i++) begin
      #1 chk("wait_no_valid", {31'h0, out_valid}, 32'h0);
      step();
    end
    data_data_ok = 1'b1; data_rdata = rdata;
    step();
    data_data_ok = 1'b0;
    #1 chk("done_valid", {31'h0, out_valid}, 32'h1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_result = '0; in_rkd_value = '0;
    in_load_op = '0; in_res_from_mem = 1'b0; in_gr_we = 1'b0; in_mem_we = 1'b0; in_dest = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; out_ready = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_data_req", {31'h0, data_req}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h1c000000);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_gr_we", {31'h0, out_gr_we}, 32'h0);
    chk("rst_out_dest", {27'h0, out_dest}, 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    #1 chk("idle_in_ready", {31'h0, in_ready}, 32'h1);
    step();

    // ALU op: result one cycle after accept, no bus traffic
    req_snap = req_cycles;
    issue(32'h1c000010, 32'h1234, 32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 1'b1, 1'b1);
    #1 chk("alu_out_valid", {31'h0, out_valid}, 32'h1);
    chk("alu_data_req", {31'h0, data_req}, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("alu_ale", {31'h0, ale}, 32'h0);
`endif
    step();
    #1 chk("alu_back_idle", {31'h0, out_valid}, 32'h0);
    chk("alu_no_req", req_cycles, req_snap);

    // ld.b with sign extension from the top byte
    issue(32'h1c000020, 32'h1c001003, 32'h0, 8'h01, 1'b1, 1'b1, 1'b0, 5'd7, 32'hFFFFFF80, 1'b1, 1'b1);
    #1 chk("ldb_req", {31'h0, data_req}, 32'h1);
    chk("ldb_size", {30'h0, data_size}, 32'h0);
    chk("ldb_wr", {31'h0, data_wr}, 32'h0);
    chk("ldb_wstrb", {28'h0, data_wstrb}, 32'h0);
    chk("ldb_addr", data_addr, 32'h1c001003);
    mem_beats(0, 1, 32'h80FF0000);
    step();

    // ld.bu zero-extends the same byte
    issue(32'h1c000024, 32'h1c001003, 32'h0, 8'h08, 1'b1, 1'b1, 1'b0, 5'd8, 32'h00000080, 1'b1, 1'b1);
    mem_beats(0, 0, 32'h80FF0000);
    step();

    // ld.h from the upper half
    issue(32'h1c000028, 32'h1c001002, 32'h0, 8'h02, 1'b1, 1'b1, 1'b0, 5'd9, 32'hFFFF8001, 1'b1, 1'b1);
    #1 chk("ldh_size", {30'h0, data_size}, 32'h1);
    mem_beats(1, 0, 32'h80011234);
    step();

    // st.h to upper half; addr_ok and data_ok together in REQ count as addr_ok only
    issue(32'h1c000030, 32'h2, 32'hAAAABEEF, 8'h40, 1'b0, 1'b0, 1'b1, 5'd0, 32'h2, 1'b1, 1'b0);
    #1 chk("sth_wr", {31'h0, data_wr}, 32'h1);
    chk("sth_wstrb", {28'h0, data_wstrb}, 32'hC);
    chk("sth_wdata", data_wdata, 32'hBEEFBEEF);
    chk("sth_size", {30'h0, data_size}, 32'h1);
    data_addr_ok = 1'b1; data_data_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1 chk("sth_wait1", {31'h0, out_valid}, 32'h0);
    step();
    #1 chk("sth_wait2", {31'h0, out_valid}, 32'h0);
    data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    #1 chk("sth_done", {31'h0, out_valid}, 32'h1);
    step();

    // st.b lane replication and shifted strobe
    issue(32'h1c000034, 32'h1c001001, 32'h1234565A, 8'h20, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1c001001, 1'b1, 1'b0);
    #1 chk("stb_wstrb", {28'h0, data_wstrb}, 32'h2);
    chk("stb_wdata", data_wdata, 32'h5A5A5A5A);
    chk("stb_size", {30'h0, data_size}, 32'h0);
    mem_beats(0, 0, 32'h0);
    step();

    // ld.w with addr_ok stalled 5 cycles, writeback stalled 3 cycles, then back-to-back ALU op
    issue(32'h1c000040, 32'h1c001000, 32'h0, 8'h04, 1'b1, 1'b1, 1'b0, 5'd9, 32'hCAFEF00D, 1'b1, 1'b1);
    in_valid = 1'b1; in_pc = 32'h1c000044; in_result = 32'h55; in_load_op = 8'h00;
    in_res_from_mem = 1'b0; in_gr_we = 1'b1; in_mem_we = 1'b0; in_dest = 5'd3;
    push_exp(32'h1c000044, 32'h55, 1'b1, 1'b1, 5'd3);
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_req", {31'h0, data_req}, 32'h1);
      chk("stall_addr", data_addr, 32'h1c001000);
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      step();
    end
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D; out_ready = 1'b0;
    step();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_result", out_result, 32'hCAFEF00D);
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
      step();
    end
    out_ready = 1'b1;
    #1 chk("b2b_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    #1 chk("b2b_valid", {31'h0, out_valid}, 32'h1);
    chk("b2b_pc", out_pc, 32'h1c000044);
    step();
    #1 chk("b2b_idle", {31'h0, out_valid}, 32'h0);

    // Reset in WAIT abandons the load; a stale data_ok afterwards is ignored
    issue(32'h1c000060, 32'h1c001004, 32'h0, 8'h04, 1'b1, 1'b1, 1'b0, 5'd10, 32'h0, 1'b0, 1'b1);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    rst = 1'b1;
    step();
    void'(exp_q.pop_back());
    pushed--;
    #1 chk("rstw_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rstw_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rstw_data_req", {31'h0, data_req}, 32'h0);
    rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    step();
    data_data_ok = 1'b0;
    #1 chk("stale_out_valid", {31'h0, out_valid}, 32'h0);
    chk("stale_out_pc", out_pc, 32'h1c000000);
    step();
    #1 chk("stale_still_idle", {31'h0, out_valid}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned ld.w traps straight to DONE without a bus request
    req_snap = req_cycles;
    issue(32'h1c000070, 32'h6, 32'h0, 8'h04, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 1'b0, 1'b0);
    #1 chk("ale_flag", {31'h0, ale}, 32'h1);
    chk("ale_data_req", {31'h0, data_req}, 32'h0);
    chk("ale_out_valid", {31'h0, out_valid}, 32'h1);
    chk("ale_gr_we", {31'h0, out_gr_we}, 32'h0);
    step();
    chk("ale_no_req", req_cycles, req_snap);
`endif

    step();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    chk("sb_count", popped, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
